ctrl_status_regs: RTL

//  Parametrised host<->FPGA register file on the bus_clk command channel.

---
 rtl/ctrl_status_pkg.sv | 23 ++
 rtl/ctrl_status_regs_event_counter.sv | 23 ++
 rtl/ctrl_status_regs.sv | 133 +++++++++++++
 3 files changed

// File: rtl/ctrl_status_pkg.sv
// rtl/ctrl_status_pkg.sv - shared address-map helpers and decode region type
package ctrl_status_pkg;

    typedef enum logic [2:0] {
        REG_CTRL,
        REG_PULSE,
        REG_CNT_LO,
        REG_CNT_HI,
        REG_ERR,
        REG_NONE
    } reg_region_e;

    // The pulse register sits directly above the control block.
    function automatic int pulse_addr(input int n_ctrl);
        return n_ctrl;
    endfunction

    // The error register is always the top word of the address space.
    function automatic int err_addr(input int addr_w);
        return (1 << addr_w) - 1;
    endfunction

endpackage

// File: rtl/ctrl_status_regs_event_counter.sv
// rtl/ctrl_status_regs_event_counter.sv - saturating event counter with priority clear
module event_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    // Clear drops any same-cycle increment; all-ones is held rather than wrapped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !(&cnt)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ctrl_status_regs.sv
// rtl/ctrl_status_regs.sv - host register file: control words, command pulses, event counters, error flag
module ctrl_status_regs
    import ctrl_status_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 5,
    parameter int N_CTRL   = 8,
    parameter int N_CNT    = 4,
    parameter int CNT_BASE = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        din,
    input  logic                     we,
    input  logic                     re,
    input  logic [ADDR_W-1:0]        addr,
    output logic [DATA_W-1:0]        dout,
    output logic [N_CTRL*DATA_W-1:0] ctrl_q,
    output logic [DATA_W-1:0]        cmd_pulse,
    input  logic [N_CNT-1:0]         evt,
    output logic                     err
);

    localparam int CNT_W      = 2 * DATA_W;
    localparam int PULSE_ADDR = pulse_addr(N_CTRL);
    localparam int ERR_ADDR   = err_addr(ADDR_W);
    localparam int CTRL_IW    = (N_CTRL > 1) ? $clog2(N_CTRL) : 1;
    localparam int CNT_IW     = (N_CNT > 1) ? $clog2(N_CNT) : 1;

    if (N_CTRL + 1 > CNT_BASE) begin : g_chk_ctrl
        $error("ctrl_status_regs: control block and pulse word overlap the counter block");
    end
    if (CNT_BASE + 2 * N_CNT > ERR_ADDR) begin : g_chk_cnt
        $error("ctrl_status_regs: counter block overlaps the error register");
    end

    reg_region_e                    region;
    int                             addr_i;
    logic [ADDR_W-1:0]              cnt_off;
    logic [CTRL_IW-1:0]             ctrl_idx;
    logic [CNT_IW-1:0]              cnt_idx;
    logic [N_CTRL-1:0][DATA_W-1:0]  ctrl_r;
    logic [N_CNT-1:0][CNT_W-1:0]    cnt;
    logic [N_CNT-1:0][DATA_W-1:0]   shadow;
    logic [N_CNT-1:0]               cnt_clr;
    logic [DATA_W-1:0]              rd_data;
    logic                           wr_cnt;
    logic                           lo_rd;

    always_comb begin
        addr_i   = int'(addr);
        cnt_off  = addr - ADDR_W'(CNT_BASE);
        ctrl_idx = CTRL_IW'(addr);
        cnt_idx  = CNT_IW'(cnt_off >> 1);
        region   = REG_NONE;
        if (addr_i < N_CTRL) begin
            region = REG_CTRL;
        end else if (addr_i == PULSE_ADDR) begin
            region = REG_PULSE;
        end else if (addr_i >= CNT_BASE && addr_i < CNT_BASE + 2 * N_CNT) begin
            region = cnt_off[0] ? REG_CNT_HI : REG_CNT_LO;
        end else if (addr_i == ERR_ADDR) begin
            region = REG_ERR;
        end
    end

    assign wr_cnt = we && (region == REG_CNT_LO || region == REG_CNT_HI);
    assign lo_rd  = re && (region == REG_CNT_LO);

    for (genvar k = 0; k < N_CNT; k++) begin : g_cnt
        assign cnt_clr[k] = wr_cnt && (int'(cnt_idx) == k);

        event_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk (clk),
            .rst (rst),
            .inc (evt[k]),
            .clr (cnt_clr[k]),
            .cnt (cnt[k])
        );
    end

    // Hi word is captured when lo is read so a lo-then-hi pair is coherent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '0;
        end else begin
            for (int i = 0; i < N_CNT; i++) begin
                if (cnt_clr[i]) begin
                    shadow[i] <= '0;
                end else if (lo_rd && int'(cnt_idx) == i) begin
                    shadow[i] <= cnt[i][CNT_W-1:DATA_W];
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (region)
            REG_CTRL:   rd_data = ctrl_r[ctrl_idx];
            REG_CNT_LO: rd_data = cnt[cnt_idx][DATA_W-1:0];
            REG_CNT_HI: rd_data = shadow[cnt_idx];
            REG_ERR:    rd_data = {{(DATA_W-1){1'b0}}, err};
            default:    rd_data = '0;
        endcase
    end

    // Reads sample pre-edge state, so a same-cycle write is not yet visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_r    <= '0;
            cmd_pulse <= '0;
            err       <= 1'b0;
            dout      <= '0;
        end else begin
            if (we && region == REG_CTRL) begin
                ctrl_r[ctrl_idx] <= din;
            end
            cmd_pulse <= (we && region == REG_PULSE) ? din : '0;
            if (we && region == REG_ERR && din[0]) begin
                err <= 1'b0;
            end else if ((we && region == REG_NONE) || (re && region == REG_PULSE)) begin
                err <= 1'b1;
            end
            if (re) begin
                dout <= rd_data;
            end
        end
    end

    assign ctrl_q = ctrl_r;

endmodule
